// File: rtl/rvfi_dmem_responder_if.sv
// Core-side valid/ready load/store bus.
// The core drives master and the responder model takes slave.
interface rvfi_dmem_responder_if #(
  parameter int XLEN = 32
) ();
  localparam int NB = XLEN / 8;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [NB-1:0]   req_wstrb;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;

  modport master (
    output req_valid,
    output req_addr,
    output req_wstrb,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_wstrb,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata
  );
endinterface

// File: rtl/rvfi_dmem_responder.sv
// Single-outstanding data-memory responder with a word-array store.
// Emits one RVFI memory record per completed access.
module rvfi_dmem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  rvfi_dmem_responder_if.slave bus,
  output logic                 rvfi_valid,
  output logic [XLEN-1:0]      rvfi_mem_addr,
  output logic [XLEN/8-1:0]    rvfi_mem_rmask,
  output logic [XLEN/8-1:0]    rvfi_mem_wmask,
  output logic [XLEN-1:0]      rvfi_mem_rdata,
  output logic [XLEN-1:0]      rvfi_mem_wdata
);
  localparam int NB = XLEN / 8;
  localparam int OB = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] addr_q;
  logic [NB-1:0]   wstrb_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] mem_q [DEPTH];

  logic [XLEN-1:0] addr_d;
  logic [XLEN-1:0] wdata_d;
  logic [XLEN-1:0] rdata_d;
  logic [IW-1:0]   rd_idx;
  logic            rd_is_wr;
  logic            commit;

  // Byte offset bits never select anything: accesses are word aligned.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.req_addr[OB-1:0];

  assign addr_d = {bus.req_addr[XLEN-1:OB], {OB{1'b0}}};
  assign commit = (state_q == RESP) && bus.resp_ready;

  // Store data with unstrobed lanes zeroed, as reported in the record.
  always_comb begin
    wdata_d = '0;
    for (int i = 0; i < NB; i++) begin
      if (bus.req_wstrb[i]) begin
        wdata_d[8*i +: 8] = bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Load data seen on the edge that enters RESP; stores return zero.
  always_comb begin
    if (LATENCY == 1) begin
      rd_idx   = bus.req_addr[OB +: IW];
      rd_is_wr = |bus.req_wstrb;
    end else begin
      rd_idx   = addr_q[OB +: IW];
      rd_is_wr = |wstrb_q;
    end
    rdata_d = rd_is_wr ? '0 : mem_q[rd_idx];
  end

  // Request FSM with registered handshake outputs and captured request.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= addr_d;
            wstrb_q     <= bus.req_wstrb;
            wdata_q     <= wdata_d;
            req_ready_q <= 1'b0;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              rdata_q      <= rdata_d;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= rdata_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            rdata_q      <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Store commits strobed lanes on the response handshake only.
  always_ff @(posedge clock) begin
    if (!reset && commit) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb_q[i]) begin
          mem_q[addr_q[OB +: IW]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;

  assign rvfi_valid     = resp_valid_q & bus.resp_ready;
  assign rvfi_mem_addr  = rvfi_valid ? addr_q : '0;
  assign rvfi_mem_rmask = (rvfi_valid && wstrb_q == '0) ? '1 : '0;
  assign rvfi_mem_wmask = rvfi_valid ? wstrb_q : '0;
  assign rvfi_mem_rdata = rvfi_valid ? rdata_q : '0;
  assign rvfi_mem_wdata = rvfi_valid ? wdata_q : '0;
endmodule

// File: tb/tb_rvfi_dmem_responder.sv
// Bench for rvfi_dmem_responder: directed and random accesses
// checked against a word-array reference memory.
module tb_rvfi_dmem_responder;
  localparam int LAT   = 3;
  localparam int DEPTH = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rvfi_valid;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;

  rvfi_dmem_responder_if #(.XLEN(32)) bus ();

  rvfi_dmem_responder #(
    .XLEN(32),
    .DEPTH(DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .rvfi_valid(rvfi_valid),
    .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask),
    .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails = 0;
  int recs = 0;
  int exp_recs = 0;
  logic [31:0] model [DEPTH];

  always @(posedge clock) begin
    if (rvfi_valid === 1'b1) recs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, input int hold);
    int n;
    int idx;
    logic [31:0] er;
    logic [31:0] ew;
    logic [31:0] lm;
    idx = int'((a >> 2) % DEPTH);
    lm = 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) lm[8*i +: 8] = 8'hFF;
    er = (s == 4'h0) ? model[idx] : 32'h0;
    ew = d & lm;
    @(negedge clock);
    chk("req_ready", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_addr   = a;
    bus.req_wstrb  = s;
    bus.req_wdata  = d;
    bus.resp_ready = 1'b0;
    @(negedge clock);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wstrb = 4'($urandom);
    bus.req_wdata = $urandom;
    n = 1;
    while (bus.resp_valid !== 1'b1 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("resp_rdata", bus.resp_rdata, er);
    for (int k = 0; k < hold; k++) begin
      chk("rvfi_early", {31'b0, rvfi_valid}, 32'd0);
      @(negedge clock);
      chk("hold_valid", {31'b0, bus.resp_valid}, 32'd1);
      chk("hold_rdata", bus.resp_rdata, er);
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("rvfi_valid", {31'b0, rvfi_valid}, 32'd1);
    chk("rvfi_addr", rvfi_mem_addr, a & 32'hFFFF_FFFC);
    chk("rvfi_rmask", {28'b0, rvfi_mem_rmask},
        (s == 4'h0) ? 32'hF : 32'h0);
    chk("rvfi_wmask", {28'b0, rvfi_mem_wmask}, {28'b0, s});
    chk("rvfi_rdata", rvfi_mem_rdata, er);
    chk("rvfi_wdata", rvfi_mem_wdata, ew);
    @(posedge clock);
    model[idx] = (model[idx] & ~lm) | ew;
    exp_recs++;
    @(negedge clock);
    bus.resp_ready = 1'b0;
    #1;
    chk("resp_done", {31'b0, bus.resp_valid}, 32'd0);
    chk("rvfi_done", {31'b0, rvfi_valid}, 32'd0);
  endtask

  initial begin
    int acc[$];
    int n;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wstrb  = 4'h0;
    bus.req_wdata  = 32'h0;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_rvfi_valid", {31'b0, rvfi_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_rvfi_addr", rvfi_mem_addr, 32'h0);
    chk("rst_rvfi_wdata", rvfi_mem_wdata, 32'h0);
    reset = 1'b0;
    bus.resp_ready = 1'b0;

    for (int i = 0; i < DEPTH; i++) txn(32'(i * 4), 4'hF, $urandom, 0);

    txn(32'h10, 4'hF, 32'hDEAD_BEEF, 0);
    txn(32'h10, 4'h0, $urandom, 1);

    txn(32'h4, 4'hF, 32'h1122_3344, 0);
    txn(32'h4, 4'h2, 32'h5566_AA77, 0);
    txn(32'h4, 4'h0, 32'h0, 0);

    txn(32'h14, 4'h0, 32'h0, 3);

    @(negedge clock);
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h8;
    bus.req_wstrb = 4'hF;
    bus.req_wdata = 32'h55AA_55AA;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("wait_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("midrst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("midrst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("midrst_rvfi", {31'b0, rvfi_valid}, 32'd0);
    bus.resp_ready = 1'b0;
    txn(32'h8, 4'h0, 32'h0, 0);

    txn(32'h0, 4'hF, 32'hCAFE_F00D, 0);
    txn(32'h40, 4'h0, 32'h0, 0);

    @(negedge clock);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h13;
    bus.req_wstrb  = 4'h0;
    bus.resp_ready = 1'b1;
    for (int c = 0; c < 4 * (LAT + 1) + 2; c++) begin
      if (bus.req_ready === 1'b1) acc.push_back(c);
      if (rvfi_valid === 1'b1) begin
        chk("b2b_addr", rvfi_mem_addr, 32'h10);
        chk("b2b_rdata", rvfi_mem_rdata, model[4]);
      end
      @(negedge clock);
    end
    bus.req_valid = 1'b0;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      if (rvfi_valid === 1'b1) chk("b2b_addr", rvfi_mem_addr, 32'h10);
      @(negedge clock);
      n++;
    end
    chk("b2b_drain", {31'b0, bus.req_ready}, 32'd1);
    bus.resp_ready = 1'b0;
    exp_recs += acc.size();
    chk("b2b_accepts", (acc.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 1; i < acc.size(); i++)
      chk("b2b_spacing", 32'(acc[i] - acc[i-1]), 32'(LAT + 1));

    for (int t = 0; t < 40; t++) begin
      logic [3:0] s;
      s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      txn(32'($urandom_range(0, 255)), s, $urandom, $urandom_range(0, 3));
    end

    @(negedge clock);
    chk("records", 32'(recs), 32'(exp_recs));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
